axi_mem_slave: RTL

AXI4 memory responder serving the data cache's refill (8-beat WRAP read) and write-back (8-beat INCR write) bursts, one transaction at a time, from an internal 64-bit word array. It sits at the slave end of the cache's AXI port in simulation and FPGA bring-up builds. It also serves as the bench memory for cache verification.

---
 rtl/axi_mem_slave_if.sv | 66 ++++++
 rtl/axi_mem_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if
//   AXI4 channel bundle between the data cache (master) and axi_mem_slave
//   (slave): AW, W, B, AR and R channels. There is no resp field (responses are
//   always OKAY), no size field (beats are always 8 bytes) and no write burst type.
//   Modports: slave  - memory side (drives ready/response/read-data signals)
//             master - cache side (drives address/write-data/ready-for-response)
interface axi_mem_slave_if #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic                  bvalid;
  logic                  bready;

  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bvalid,
    input  bready,
    input  arid, araddr, arlen, arburst, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bvalid,
    output bready,
    output arid, araddr, arlen, arburst, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave
//   AXI4 memory responder for the data cache: serves one transaction at a time
//   (refill WRAP reads, write-back INCR writes) from an internal array of
//   MEM_WORDS 64-bit words. Word index = addr[3 +: log2(MEM_WORDS)]; higher
//   address bits alias. Memory contents are not cleared by reset.
// Ports
//   clk   - clock, rising edge
//   reset - synchronous, active-high; returns to IDLE and abandons any burst
//   bus   - axi_mem_slave_if.slave (AW/W/B/AR/R channels)
// Build option
//   AXI_MEM_WRAP_EN - when defined, arburst = 2 with len+1 in {2,4,8,16} wraps
//                     within the aligned block; when undefined every read is INCR.
module axi_mem_slave #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_WORDS  = 4096
) (
  input logic            clk,
  input logic            reset,
  axi_mem_slave_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    wrap_mask_q, wrap_mask_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_adv;
  logic                mem_we;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Address bits that never select a word (byte offset, aliased upper bits).
  logic unused_addr_bits;
  always_comb unused_addr_bits = ^{bus.awaddr[2:0], bus.awaddr[ADDR_WIDTH-1:3+IDX_W],
                                   bus.araddr[2:0], bus.araddr[ADDR_WIDTH-1:3+IDX_W]
`ifndef AXI_MEM_WRAP_EN
                                   , bus.arburst
`endif
                                   };

  // A non-zero mask marks the pointer bits that wrap inside the aligned block;
  // the bits above the mask stay fixed for the whole burst.
  always_comb begin
    if (wrap_mask_q != '0)
      ptr_adv = (ptr_q & ~wrap_mask_q) | ((ptr_q + IDX_W'(1)) & wrap_mask_q);
    else
      ptr_adv = ptr_q + IDX_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    wrap_mask_d = wrap_mask_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.awvalid) begin
          id_d        = bus.awid;
          ptr_d       = bus.awaddr[3 +: IDX_W];
          len_d       = bus.awlen;
          cnt_d       = '0;
          wrap_mask_d = '0;
          state_d     = WDATA;
        end else if (bus.arvalid) begin
          id_d  = bus.arid;
          ptr_d = bus.araddr[3 +: IDX_W];
          len_d = bus.arlen;
          cnt_d = '0;
`ifdef AXI_MEM_WRAP_EN
          if (bus.arburst == 2'd2 &&
              (bus.arlen == 8'd1 || bus.arlen == 8'd3 || bus.arlen == 8'd7 || bus.arlen == 8'd15))
            wrap_mask_d = IDX_W'(bus.arlen[3:0]);
          else
            wrap_mask_d = '0;
`else
          wrap_mask_d = '0;
`endif
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (bus.wvalid) begin
          ptr_d = ptr_adv;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q || bus.wlast) state_d = WRESP;
        end
      end
      WRESP: begin
        if (bus.bready) state_d = IDLE;
      end
      RDATA: begin
        if (bus.rready) begin
          ptr_d = ptr_adv;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.awready = (state_q == IDLE);
    bus.arready = (state_q == IDLE) && !bus.awvalid;
    bus.wready  = (state_q == WDATA);
    bus.bvalid  = (state_q == WRESP);
    bus.bid     = id_q;
    bus.rvalid  = (state_q == RDATA);
    bus.rlast   = (state_q == RDATA) && (cnt_q == len_q);
    bus.rid     = id_q;
    bus.rdata   = mem_q[ptr_q];
  end

  always_comb mem_we = (state_q == WDATA) && bus.wvalid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      ptr_q       <= '0;
      wrap_mask_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      wrap_mask_q <= wrap_mask_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
        if (bus.wstrb[b]) mem_q[ptr_q][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end
endmodule
